// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared widths and output beat type for the convolution datapath
package conv_pkg;

    localparam int IO_DATA_WIDTH      = 16;
    localparam int ACCUMULATION_WIDTH = 32;
    localparam int FEATURE_MAP_WIDTH  = 1024;
    localparam int FEATURE_MAP_HEIGHT = 1024;
    localparam int OUTPUT_NB_CHANNELS = 64;
    localparam int XW                 = $clog2(FEATURE_MAP_WIDTH);
    localparam int YW                 = $clog2(FEATURE_MAP_HEIGHT);
    localparam int CW                 = $clog2(OUTPUT_NB_CHANNELS);

    // One packed output beat; word_1 carries the lowest channel of the group.
    typedef struct packed {
        logic [IO_DATA_WIDTH-1:0] word_3;
        logic [IO_DATA_WIDTH-1:0] word_2;
        logic [IO_DATA_WIDTH-1:0] word_1;
        logic [2:0]               lanes;
        logic [XW-1:0]            x;
        logic [YW-1:0]            y;
        logic [CW-1:0]            ch;
    } out_beat_t;

endpackage

// File: rtl/osb_fifo.sv
// rtl/osb_fifo.sv - beat FIFO with a registered head word
module osb_fifo
    import conv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  out_beat_t push_data,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output out_beat_t head
);

    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            NW      = $clog2(DEPTH + 1);
    localparam logic [NW-1:0] DEPTH_N = NW'(DEPTH);

    out_beat_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [NW-1:0] mem_count;
    logic [NW-1:0] occupancy;
    logic          head_valid;
    logic          load;

    // The head register counts toward occupancy, so DEPTH beats in total
    // (array plus head) make the FIFO full.
    always_comb begin
        load      = (mem_count != '0) && (!head_valid || pop);
        occupancy = mem_count + NW'(head_valid);
        full      = (occupancy == DEPTH_N);
        empty     = !head_valid;
    end

    // Storage array: entries are only read after being written, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, array count and head register; head refills on the pop edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_count  <= '0;
            head_valid <= 1'b0;
            head       <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr     <= rd_ptr + 1'b1;
                head       <= mem[rd_ptr];
                head_valid <= 1'b1;
            end else if (pop) begin
                head_valid <= 1'b0;
            end
            mem_count <= mem_count + NW'(push) - NW'(load);
        end
    end

endmodule

// File: rtl/output_stage_buffer.sv
// rtl/output_stage_buffer.sv - requantize, pack and buffer conv results; OUTPUT_STAGE_BUFFER_SATURATE_EN selects clamping
module output_stage_buffer
    import conv_pkg::*;
#(
    parameter int REQ_SHIFT  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          arst_n_in,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ACCUMULATION_WIDTH-1:0] in_data,
    input  logic [XW-1:0]                 in_x,
    input  logic [YW-1:0]                 in_y,
    input  logic [CW-1:0]                 in_ch,
    input  logic                          in_last,
    output logic                          output_valid,
    input  logic                          output_ready,
    output logic [IO_DATA_WIDTH-1:0]      out_1,
    output logic [IO_DATA_WIDTH-1:0]      out_2,
    output logic [IO_DATA_WIDTH-1:0]      out_3,
    output logic [2:0]                    out_lanes,
    output logic [XW-1:0]                 output_x,
    output logic [YW-1:0]                 output_y,
    output logic [CW-1:0]                 output_ch,
    output logic                          driving_cons
);

    logic                     accept;
    logic                     close;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [IO_DATA_WIDTH-1:0] q;
    logic [1:0]               lane_count;
    logic [IO_DATA_WIDTH-1:0] word_1_q;
    logic [IO_DATA_WIDTH-1:0] word_2_q;
    logic [XW-1:0]            beat_x;
    logic [YW-1:0]            beat_y;
    logic [CW-1:0]            beat_ch;
    out_beat_t                beat;
    out_beat_t                head;

    assign in_ready = !fifo_full;
    assign accept   = in_valid && in_ready;

`ifdef OUTPUT_STAGE_BUFFER_SATURATE_EN
    localparam logic signed [ACCUMULATION_WIDTH-1:0] Q_MAX =
        ACCUMULATION_WIDTH'(2 ** (IO_DATA_WIDTH - 1) - 1);
    localparam logic signed [ACCUMULATION_WIDTH-1:0] Q_MIN = ~Q_MAX;

    logic signed [ACCUMULATION_WIDTH-1:0] shifted;

    // Floor shift, then clamp to the signed output word range.
    always_comb begin
        shifted = $signed(in_data) >>> REQ_SHIFT;
        if (shifted > Q_MAX) begin
            q = Q_MAX[IO_DATA_WIDTH-1:0];
        end else if (shifted < Q_MIN) begin
            q = Q_MIN[IO_DATA_WIDTH-1:0];
        end else begin
            q = shifted[IO_DATA_WIDTH-1:0];
        end
    end
`else
    // Floor shift, then keep the low word bits (two's-complement wrap).
    always_comb begin
        q = IO_DATA_WIDTH'($signed(in_data) >>> REQ_SHIFT);
    end
`endif

    // Assemble the beat that would be pushed if this accept closes it; the
    // third lane never needs a register because filling it always closes.
    always_comb begin
        beat  = '0;
        close = accept && (in_last || (lane_count == 2'd2));
        case (lane_count)
            2'd0: begin
                beat.word_1 = q;
                beat.lanes  = 3'b001;
                beat.x      = in_x;
                beat.y      = in_y;
                beat.ch     = in_ch;
            end
            2'd1: begin
                beat.word_1 = word_1_q;
                beat.word_2 = q;
                beat.lanes  = 3'b011;
                beat.x      = beat_x;
                beat.y      = beat_y;
                beat.ch     = beat_ch;
            end
            default: begin
                beat.word_1 = word_1_q;
                beat.word_2 = word_2_q;
                beat.word_3 = q;
                beat.lanes  = 3'b111;
                beat.x      = beat_x;
                beat.y      = beat_y;
                beat.ch     = beat_ch;
            end
        endcase
    end

    // Lane counter and partial-beat registers; coordinates latch on lane 1.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            lane_count <= 2'd0;
            word_1_q   <= '0;
            word_2_q   <= '0;
            beat_x     <= '0;
            beat_y     <= '0;
            beat_ch    <= '0;
        end else if (accept) begin
            if (close) begin
                lane_count <= 2'd0;
            end else begin
                lane_count <= lane_count + 2'd1;
                if (lane_count == 2'd0) begin
                    word_1_q <= q;
                    beat_x   <= in_x;
                    beat_y   <= in_y;
                    beat_ch  <= in_ch;
                end else begin
                    word_2_q <= q;
                end
            end
        end
    end

    osb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (arst_n_in),
        .push      (close),
        .push_data (beat),
        .pop       (output_valid && output_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    assign output_valid = !fifo_empty;
    assign driving_cons = output_valid;
    assign out_1        = head.word_1;
    assign out_2        = head.word_2;
    assign out_3        = head.word_3;
    assign out_lanes    = head.lanes;
    assign output_x     = head.x;
    assign output_y     = head.y;
    assign output_ch    = head.ch;

endmodule
